// File: rtl/tc_mul_rsp_collect.sv
// Purpose: pairs tensor-core multiply results with in-order issue sideband tags and queues them for writeback.
// Latency: one cycle from an accepted multiply response to wb_valid_o when the output queue is empty.
// Backpressure: 2-entry output queue drives mul_ready_o (no wb_ready bypass); iss_allow_o gates issue when the tag FIFO is full.
module tc_mul_rsp_collect #(
    parameter int SHAPE_K       = 8,
    parameter int ELEMENT_WIDTH = 9,
    parameter int CTRL_C_WIDTH  = 16,
    parameter int DEPTH_WARP    = 4,
    parameter int TAG_DEPTH     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              iss_valid_i,
    input  logic                              iss_ready_i,
    input  logic [CTRL_C_WIDTH-1:0]           iss_ctrl_c_i,
    input  logic [2:0]                        iss_rm_i,
    input  logic [7:0]                        iss_reg_idxw_i,
    input  logic [DEPTH_WARP-1:0]             iss_warpid_i,
    output logic                              iss_allow_o,
    input  logic                              mul_valid_i,
    output logic                              mul_ready_o,
    input  logic [SHAPE_K*ELEMENT_WIDTH-1:0]  mul_result_i,
    input  logic [4:0]                        mul_fflags_i,
    output logic                              wb_valid_o,
    input  logic                              wb_ready_i,
    output logic [SHAPE_K*ELEMENT_WIDTH-1:0]  wb_result_o,
    output logic [4:0]                        wb_fflags_o,
    output logic [CTRL_C_WIDTH-1:0]           wb_ctrl_c_o,
    output logic [2:0]                        wb_rm_o,
    output logic [7:0]                        wb_reg_idxw_o,
    output logic [DEPTH_WARP-1:0]             wb_warpid_o,
    output logic [$clog2(TAG_DEPTH):0]        inflight_o,
    output logic [4:0]                        fflags_acc_o,
    input  logic                              clr_i,
    output logic                              err_o
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = SHAPE_K * ELEMENT_WIDTH;

    typedef struct packed {
        logic [CTRL_C_WIDTH-1:0] ctrl_c;
        logic [2:0]              rm;
        logic [7:0]              reg_idxw;
        logic [DEPTH_WARP-1:0]   warpid;
    } tag_t;

    typedef struct packed {
        logic [RW-1:0] result;
        logic [4:0]    fflags;
        tag_t          tag;
    } rsp_t;

    tag_t            tag_mem [TAG_DEPTH];
    logic [PW-1:0]   tag_wr_ptr;
    logic [PW-1:0]   tag_rd_ptr;
    logic [CW-1:0]   tag_cnt;

    rsp_t            oq_mem [2];
    logic            oq_wr_ptr;
    logic            oq_rd_ptr;
    logic [1:0]      oq_cnt;

    logic            tag_push;
    logic            tag_full;
    logic            tag_empty;
    logic            tag_wr_en;
    logic            tag_rd_en;
    logic            mul_fire;
    logic            wb_fire;
    logic            proto_err;
    tag_t            new_tag;
    tag_t            head_tag;
    rsp_t            new_rsp;
    rsp_t            oq_head;

    assign tag_push  = iss_valid_i & iss_ready_i;
    assign tag_full  = (tag_cnt == CW'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign tag_wr_en = tag_push & ~tag_full;
    assign mul_fire  = mul_valid_i & mul_ready_o;
    // Underflow is judged on the pre-push count, so a same-cycle push never feeds the pop.
    assign tag_rd_en = mul_fire & ~tag_empty;
    assign wb_fire   = wb_valid_o & wb_ready_i;
    assign proto_err = (tag_push & tag_full) | (mul_fire & tag_empty);

    assign new_tag   = '{ctrl_c: iss_ctrl_c_i, rm: iss_rm_i, reg_idxw: iss_reg_idxw_i, warpid: iss_warpid_i};
    assign head_tag  = tag_empty ? '0 : tag_mem[tag_rd_ptr];
    assign new_rsp   = '{result: mul_result_i, fflags: mul_fflags_i, tag: head_tag};
    assign oq_head   = oq_mem[oq_rd_ptr];

    assign iss_allow_o   = ~tag_full;
    assign mul_ready_o   = (oq_cnt < 2'd2);
    assign wb_valid_o    = (oq_cnt != 2'd0);
    assign wb_result_o   = oq_head.result;
    assign wb_fflags_o   = oq_head.fflags;
    assign wb_ctrl_c_o   = oq_head.tag.ctrl_c;
    assign wb_rm_o       = oq_head.tag.rm;
    assign wb_reg_idxw_o = oq_head.tag.reg_idxw;
    assign wb_warpid_o   = oq_head.tag.warpid;
    assign inflight_o    = tag_cnt;

    // Tag storage: data-only, validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (tag_wr_en) begin
            tag_mem[tag_wr_ptr] <= new_tag;
        end
    end

    // Tag FIFO pointers and occupancy; an overflowing push is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_cnt    <= '0;
        end else begin
            if (tag_wr_en) tag_wr_ptr <= tag_wr_ptr + PW'(1);
            if (tag_rd_en) tag_rd_ptr <= tag_rd_ptr + PW'(1);
            case ({tag_wr_en, tag_rd_en})
                2'b10:   tag_cnt <= tag_cnt + CW'(1);
                2'b01:   tag_cnt <= tag_cnt - CW'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Output queue: entries are reset so the wb_* data reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oq_mem[0] <= '0;
            oq_mem[1] <= '0;
            oq_wr_ptr <= 1'b0;
            oq_rd_ptr <= 1'b0;
            oq_cnt    <= 2'd0;
        end else begin
            if (mul_fire) begin
                oq_mem[oq_wr_ptr] <= new_rsp;
                oq_wr_ptr         <= ~oq_wr_ptr;
            end
            if (wb_fire) oq_rd_ptr <= ~oq_rd_ptr;
            case ({mul_fire, wb_fire})
                2'b10:   oq_cnt <= oq_cnt + 2'd1;
                2'b01:   oq_cnt <= oq_cnt - 2'd1;
                default: oq_cnt <= oq_cnt;
            endcase
        end
    end

    // Sticky fflags accumulator and protocol error; clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_acc_o <= '0;
            err_o        <= 1'b0;
        end else if (clr_i) begin
            fflags_acc_o <= '0;
            err_o        <= 1'b0;
        end else begin
            if (wb_fire)   fflags_acc_o <= fflags_acc_o | wb_fflags_o;
            if (proto_err) err_o        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tc_mul_rsp_collect.sv
// Purpose: directed bench for tc_mul_rsp_collect with a queue-based reference model checked every cycle.
// Latency: model advances once per clock; DUT outputs compared on the falling edge.
// Backpressure: stimulus exercises full tag FIFO, stalled writeback and concurrent push/pop.
module tb_tc_mul_rsp_collect;

    localparam int K  = 8;
    localparam int EW = 9;
    localparam int CC = 16;
    localparam int DW = 4;
    localparam int TD = 8;

    logic          clk;
    logic          rst;
    logic          iss_valid, iss_ready;
    logic [15:0]   iss_ctrl_c;
    logic [2:0]    iss_rm;
    logic [7:0]    iss_reg_idxw;
    logic [3:0]    iss_warpid;
    logic          iss_allow_o;
    logic          mul_valid;
    logic          mul_ready_o;
    logic [71:0]   mul_result;
    logic [4:0]    mul_fflags;
    logic          wb_valid_o;
    logic          wb_ready;
    logic [71:0]   wb_result_o;
    logic [4:0]    wb_fflags_o;
    logic [15:0]   wb_ctrl_c_o;
    logic [2:0]    wb_rm_o;
    logic [7:0]    wb_reg_idxw_o;
    logic [3:0]    wb_warpid_o;
    logic [3:0]    inflight_o;
    logic [4:0]    fflags_acc_o;
    logic          clr;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    tc_mul_rsp_collect #(
        .SHAPE_K(K), .ELEMENT_WIDTH(EW), .CTRL_C_WIDTH(CC), .DEPTH_WARP(DW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .rst(rst),
        .iss_valid_i(iss_valid), .iss_ready_i(iss_ready),
        .iss_ctrl_c_i(iss_ctrl_c), .iss_rm_i(iss_rm), .iss_reg_idxw_i(iss_reg_idxw),
        .iss_warpid_i(iss_warpid), .iss_allow_o(iss_allow_o),
        .mul_valid_i(mul_valid), .mul_ready_o(mul_ready_o),
        .mul_result_i(mul_result), .mul_fflags_i(mul_fflags),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready),
        .wb_result_o(wb_result_o), .wb_fflags_o(wb_fflags_o), .wb_ctrl_c_o(wb_ctrl_c_o),
        .wb_rm_o(wb_rm_o), .wb_reg_idxw_o(wb_reg_idxw_o), .wb_warpid_o(wb_warpid_o),
        .inflight_o(inflight_o), .fflags_acc_o(fflags_acc_o),
        .clr_i(clr), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [71:0] res;
        logic [4:0]  ff;
        logic [30:0] tag;   // {ctrl_c, rm, reg_idxw, warpid}
    } ment_t;

    logic [30:0] tq [$];
    ment_t       oq [$];
    logic        m_err;
    logic [4:0]  m_acc;

    // Compare DUT against the model, then advance the model with the inputs seen at the next edge.
    always @(negedge clk) begin : model
        int    pre;
        bit    full, push, mf, wf;
        ment_t ne;
        logic [4:0] hf;
        if (rst) begin
            tq.delete();
            oq.delete();
            m_err = 1'b0;
            m_acc = 5'd0;
        end
        check("wb_valid", wb_valid_o, oq.size() != 0);
        check("inflight", inflight_o, tq.size());
        check("iss_allow", iss_allow_o, tq.size() != TD);
        check("mul_ready", mul_ready_o, oq.size() < 2);
        check("err", err_o, m_err);
        check("fflags_acc", fflags_acc_o, m_acc);
        if (oq.size() != 0) begin
            check("wb_result", wb_result_o, oq[0].res);
            check("wb_fflags", wb_fflags_o, oq[0].ff);
            check("wb_tag", {wb_ctrl_c_o, wb_rm_o, wb_reg_idxw_o, wb_warpid_o}, oq[0].tag);
        end
        if (!rst) begin
            pre  = tq.size();
            full = (pre == TD);
            push = iss_valid && iss_ready;
            mf   = mul_valid && (oq.size() < 2);
            wf   = (oq.size() != 0) && wb_ready;
            hf   = wf ? oq[0].ff : 5'd0;
            ne   = '0;
            if (mf) begin
                ne.res = mul_result;
                ne.ff  = mul_fflags;
                ne.tag = (pre > 0) ? tq[0] : 31'd0;
            end
            if (mf && pre > 0) void'(tq.pop_front());
            if (push && !full) tq.push_back({iss_ctrl_c, iss_rm, iss_reg_idxw, iss_warpid});
            if (wf) void'(oq.pop_front());
            if (mf) oq.push_back(ne);
            if (clr) begin
                m_err = 1'b0;
                m_acc = 5'd0;
            end else begin
                if ((push && full) || (mf && pre == 0)) m_err = 1'b1;
                m_acc = m_acc | hf;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [3:0] wlog [$];

    task automatic cyc();
        if (wb_valid_o && wb_ready) wlog.push_back(wb_warpid_o);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_ready = 1; iss_ctrl_c = 0; iss_rm = 0; iss_reg_idxw = 0; iss_warpid = 0;
        mul_valid = 0; mul_result = 0; mul_fflags = 0; clr = 0;
    endtask

    task automatic issue(input logic [15:0] c, input logic [2:0] r, input logic [7:0] ri, input logic [3:0] w);
        iss_valid = 1; iss_ctrl_c = c; iss_rm = r; iss_reg_idxw = ri; iss_warpid = w;
        cyc();
        iss_valid = 0;
    endtask

    // Hold mul_valid until n responses are accepted, within a cycle budget.
    task automatic resp_n(input int n, input int seed);
        int got   = 0;
        int guard = 0;
        mul_valid = 1;
        while (got < n && guard < 64) begin
            mul_result = {K{9'(seed + got)}};
            mul_fflags = 5'(seed + got);
            if (mul_ready_o) got++;
            cyc();
            guard++;
        end
        mul_valid = 0;
        check("resp_fires", got, n);
    endtask

    task automatic single_op();
        logic [71:0] exp_res;
        exp_res  = {K{9'h0FF}};
        wb_ready = 1;
        issue(16'h1234, 3'd3, 8'h2A, 4'd5);
        check("single_inflight_1", inflight_o, 1);
        cyc();
        cyc();
        mul_valid = 1; mul_result = exp_res; mul_fflags = 5'h01;
        cyc();
        mul_valid = 0;
        check("single_wb_valid", wb_valid_o, 1);
        check("single_ctrl", {wb_ctrl_c_o, wb_rm_o, wb_reg_idxw_o, wb_warpid_o}, {16'h1234, 3'd3, 8'h2A, 4'd5});
        check("single_result", wb_result_o, exp_res);
        check("single_fflags", wb_fflags_o, 5'h01);
        check("single_inflight_0", inflight_o, 0);
        cyc();
        check("single_acc", fflags_acc_o, 5'h01);
        check("single_wb_idle", wb_valid_o, 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1; wb_ready = 0;
        idle_inputs();
        #1;
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_iss_allow", iss_allow_o, 1);
        check("rst_mul_ready", mul_ready_o, 1);
        check("rst_inflight", inflight_o, 0);
        check("rst_wb_result", wb_result_o, 0);
        cyc();
        cyc();
        rst = 0;
        cyc();

        // Single op
        single_op();

        // Fill the tag FIFO, then overflow it
        wb_ready = 1;
        for (int i = 0; i < TD; i++) begin
            iss_valid = 1; iss_ctrl_c = 16'(i * 16'h111); iss_rm = 3'(i); iss_reg_idxw = 8'(i + 8'h40); iss_warpid = 4'(i);
            cyc();
        end
        check("fill_iss_allow", iss_allow_o, 0);
        check("fill_inflight", inflight_o, 8);
        cyc();
        iss_valid = 0;
        check("ovf_err", err_o, 1);
        check("ovf_inflight", inflight_o, 8);
        resp_n(8, 1);
        cyc();
        cyc();
        check("drain_inflight", inflight_o, 0);
        clr = 1;
        cyc();
        clr = 0;
        check("clr_err", err_o, 0);
        check("clr_acc", fflags_acc_o, 0);

        // Ordering and backpressure
        wb_ready = 0;
        wlog.delete();
        for (int i = 0; i < 4; i++) issue(16'hA000 + 16'(i), 3'd1, 8'(i), 4'(i));
        resp_n(2, 9'h100);
        mul_valid = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_mul_ready", mul_ready_o, 0);
            check("stall_warp", wb_warpid_o, 0);
            check("stall_result", wb_result_o, {K{9'h100}});
        end
        mul_valid = 0;
        wb_ready = 1;
        resp_n(2, 9'h150);
        for (int i = 0; i < 4; i++) cyc();
        check("order_count", wlog.size(), 4);
        for (int i = 0; i < wlog.size(); i++) check("order_warp", wlog[i], 4'(i));

        // Concurrency: steady issue + response
        for (int i = 0; i < 3; i++) issue(16'hC000 + 16'(i), 3'd2, 8'h10, 4'(i));
        for (int i = 0; i < 6; i++) begin
            iss_valid = 1; iss_ctrl_c = 16'hD000 + 16'(i); iss_warpid = 4'(i + 3);
            mul_valid = 1; mul_result = {K{9'(i + 9'h30)}}; mul_fflags = 5'(1 << (i % 5));
            cyc();
        end
        iss_valid = 0; mul_valid = 0;
        check("conc_inflight", inflight_o, 3);
        resp_n(3, 9'h60);
        cyc();
        cyc();
        check("conc_drained", inflight_o, 0);
        check("conc_wb_idle", wb_valid_o, 0);

        // Underflow
        clr = 1;
        cyc();
        clr = 0;
        mul_valid = 1; mul_result = {K{9'h1A5}}; mul_fflags = 5'h10;
        cyc();
        mul_valid = 0;
        check("unf_wb_valid", wb_valid_o, 1);
        check("unf_tag", {wb_ctrl_c_o, wb_rm_o, wb_reg_idxw_o, wb_warpid_o}, 31'd0);
        check("unf_result", wb_result_o, {K{9'h1A5}});
        check("unf_err", err_o, 1);
        cyc();
        check("unf_acc", fflags_acc_o, 5'h10);
        clr = 1;
        cyc();
        clr = 0;
        check("unf_clr_err", err_o, 0);
        check("unf_clr_acc", fflags_acc_o, 0);

        // Async reset mid-stream: 3 tags in flight, 2 responses queued
        wb_ready = 0;
        for (int i = 0; i < 5; i++) issue(16'hE000 + 16'(i), 3'd4, 8'h77, 4'(i));
        resp_n(2, 9'h1F0);
        check("pre_rst_inflight", inflight_o, 3);
        check("pre_rst_wb_valid", wb_valid_o, 1);
        rst = 1;
        idle_inputs();
        #1;
        check("arst_wb_valid", wb_valid_o, 0);
        check("arst_inflight", inflight_o, 0);
        check("arst_iss_allow", iss_allow_o, 1);
        check("arst_mul_ready", mul_ready_o, 1);
        check("arst_wb_result", wb_result_o, 0);
        check("arst_wb_ctrl", wb_ctrl_c_o, 0);
        cyc();
        rst = 0;
        cyc();
        single_op();
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tc_mul_rsp_collect.md
Name: tc_mul_rsp_collect

Overview:
- Response-side collector for the tensor-core multiply stage.
- Snoops the issue handshake into the multiply pipe and captures the per-instruction control sideband (ctrl_c, rm, reg_idxw, warpid) into an in-order tag FIFO.
- Accepts vector results and fflags from the multiply pipe's output handshake and pairs each with the oldest tag.
- Buffers the paired responses in a 2-entry output queue toward writeback/accumulate, limiting in-flight operations to TAG_DEPTH.

Parameters:
- SHAPE_K, 8: lanes per vector result.
- ELEMENT_WIDTH, 9: bits per lane element.
- CTRL_C_WIDTH, 16: width of the ctrl_c sideband.
- DEPTH_WARP, 4: width of the warp id.
- TAG_DEPTH, 8: tag FIFO entries. Must be a power of 2 and ≥2.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- iss_valid_i, input, 1: issue valid presented to the multiply pipe.
- iss_ready_i, input, 1: multiply pipe in_ready.
- iss_ctrl_c_i, input, CTRL_C_WIDTH: ctrl_c at issue.
- iss_rm_i, input, 3: rounding mode at issue.
- iss_reg_idxw_i, input, 8: destination register index at issue.
- iss_warpid_i, input, DEPTH_WARP: warp id at issue.
- iss_allow_o, output, 1: high when the tag FIFO can take a push. Upstream ANDs it into iss_valid.
- mul_valid_i, input, 1: multiply pipe out_valid.
- mul_ready_o, output, 1: ready to the multiply pipe out_ready.
- mul_result_i, input, SHAPE_K*ELEMENT_WIDTH: product vector.
- mul_fflags_i, input, 5: OR-reduced exception flags.
- wb_valid_o, output, 1: response valid.
- wb_ready_i, input, 1: downstream ready.
- wb_result_o, output, SHAPE_K*ELEMENT_WIDTH: head result.
- wb_fflags_o, output, 5: head fflags.
- wb_ctrl_c_o, output, CTRL_C_WIDTH: head ctrl_c.
- wb_rm_o, output, 3: head rounding mode.
- wb_reg_idxw_o, output, 8: head register index.
- wb_warpid_o, output, DEPTH_WARP: head warp id.
- inflight_o, output, $clog2(TAG_DEPTH)+1: tag FIFO occupancy.
- fflags_acc_o, output, 5: sticky OR of all fflags delivered on wb fire.
- clr_i, input, 1: synchronous clear of fflags_acc_o and err_o.
- err_o, output, 1: sticky protocol error (tag overflow or underflow).

Behaviour:
- Reset (async, rst=1) clears all state:
  - Tag FIFO and output queue pointers and counts go to 0.
  - wb_valid_o=0, all wb_* data=0, inflight_o=0, fflags_acc_o=0, err_o=0.
  - iss_allow_o=1, mul_ready_o=1.
  - Reset mid-operation discards all tags and queued responses; nothing is replayed.
- Tag FIFO:
  - Circular, read/write pointers of $clog2(TAG_DEPTH) bits with natural wrap; count of $clog2(TAG_DEPTH)+1 bits.
  - tag_push = iss_valid_i & iss_ready_i. Writes {ctrl_c, rm, reg_idxw, warpid} at the write pointer.
  - iss_allow_o = (count != TAG_DEPTH), combinational from registered count.
  - Push while full: the write is dropped, count is unchanged, err_o set.
- Response accept:
  - mul_ready_o = (oq_count < 2), registered-state only; no bypass from wb_ready_i.
  - mul_fire = mul_valid_i & mul_ready_o. Pops the tag head and writes {result, fflags, tag} into the output queue.
  - mul_fire with tag count 0 (evaluated before any same-cycle push): the entry is written with a zero tag, the pointer does not move, err_o set.
- Simultaneous tag push and pop with count>0: both pointers advance, count unchanged. A pop never returns the tag pushed in the same cycle.
- Output queue:
  - 2 entries, in-order.
  - wb_valid_o = (oq_count != 0).
  - wb_* outputs are driven from the registered head entry.
  - wb_fire = wb_valid_o & wb_ready_i pops the head.
  - Simultaneous mul_fire and wb_fire at oq_count=1: count stays 1, new head is the accepted entry.
- Latency: mul_fire in cycle t gives wb_valid_o=1 with that data in cycle t+1 when the queue was empty.
- Stability: wb_* data stays stable while wb_valid_o=1 and wb_ready_i=0.
- fflags_acc_o |= wb_fflags_o on each wb_fire. err_o is sticky.
- clr_i=1 zeroes fflags_acc_o and err_o next cycle. If clr_i coincides with a wb_fire or an error, the clear wins.
- inflight_o equals the tag FIFO count.

Test Plan:
- Single op: issue fire with ctrl_c=0x1234, rm=3, reg_idxw=0x2A, warpid=5; mul_valid 3 cycles later with result=all lanes 0x0FF, fflags=0x01, wb_ready=1 -> wb_valid_o next cycle with matching ctrl, result and fflags. inflight_o goes 1→0. fflags_acc_o=0x01.
- Fill: 8 back-to-back issues with no responses -> iss_allow_o=0 after the 8th and inflight_o=8. A 9th forced push sets err_o=1 and inflight stays 8.
- Ordering and backpressure: 4 ops with warpid 0..3, wb_ready=0 -> mul_ready_o drops after 2 accepts. Release wb_ready -> wb outputs warpid 0,1,2,3 in order and data is held stable while stalled.
- Concurrency: steady one issue and one response per cycle at inflight=3 -> inflight stays 3. With oq_count=1 and simultaneous mul_fire and wb_fire, no data is lost.
- Underflow: mul_valid with an empty tag FIFO -> wb emits the result with a zero tag and err_o=1. clr_i then clears err_o and fflags_acc_o.
- Async reset asserted mid-stream with 3 in flight and 2 queued -> all outputs reach reset values immediately; post-reset ops behave as in the single-op scenario.
